param_lfsr_rng: RTL and testbench
=================================

PARAM_LFSR_RNG -- requirements
Module: param_lfsr_rng

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning LFSR register width (legal 3..16).
REQ-002 SHALL have parameter TAPS, default 10'h0B8, meaning WIDTH-bit feedback tap mask.
REQ-003 SHALL have parameter SEED, default 0, meaning WIDTH-bit reset value of the LFSR.
REQ-004 SHALL have parameter NDIG, default 4, meaning decimal digit count (>= digits of 2^WIDTH-1).
REQ-005 SHALL have parameter BLANK_LZ, default 0, meaning 1 = blank leading-zero digits.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 step  input  1  advance LFSR one state (sampled per clk).
REQ-009 load  input  1  load seed_in into LFSR.
REQ-010 seed_in  input  WIDTH  load value.
REQ-011 value  output  WIDTH  current LFSR state.
REQ-012 bcd  output  4*NDIG  packed BCD of last converted value, digit 0 in LSBs.
REQ-013 hex  output  7*NDIG  active-low seven-segment patterns, digit 0 in LSBs.
REQ-014 busy  output  1  conversion in progress; requests ignored.
REQ-015 valid  output  1  one-cycle pulse when bcd/hex update.
REQ-016 lock_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-017 Feedback SHALL be fb = XNOR-reduce(value & TAPS); a step SHALL set value <= {fb, value[WIDTH-1:1]}.
REQ-018 Requests SHALL be accepted only when busy=0; step/load while busy=1 SHALL be dropped with no effect.
REQ-019 load SHALL take priority over step when both are high in the same cycle.
REQ-020 A load of all-ones (XNOR lockup state) SHALL be rejected: value unchanged, lock_err=1 for one cycle, no conversion started.
REQ-021 Converter FSM states SHALL be IDLE, SHIFT, DONE: an accepted request at edge k moves IDLE->SHIFT and loads the new value into the converter.
REQ-022 SHIFT SHALL last exactly WIDTH cycles of double-dabble (add 3 to any BCD nibble >=5, then shift left one bit), then move to DONE.
REQ-023 DONE->IDLE SHALL register bcd and hex and pulse valid for one cycle; valid SHALL be high for the cycle after edge k+WIDTH+1.
REQ-024 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; bcd/hex SHALL hold previous results throughout conversion.
REQ-025 Segment encoding (gfedcba, active-low) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
REQ-026 With BLANK_LZ=1, every zero digit above the most significant nonzero digit SHALL output 7F; digit 0 SHALL never be blanked.

Reset
REQ-027 Reset assertion SHALL immediately set value=SEED, bcd=0, hex=all 7F, busy=0, valid=0, lock_err=0, FSM=IDLE.
REQ-028 A pending-start flag SHALL reset to 1 so that the first cycle after reset deassertion starts a conversion of SEED, with step/load ignored in that cycle.
REQ-029 Reset asserted mid-conversion SHALL abort it; no valid pulse SHALL occur for the aborted conversion.

Structure
REQ-030 Package lfsr_rng_pkg SHALL hold the FSM state type and the ten segment encoding constants.
REQ-031 The sequential double-dabble SHALL be sub-module bcd_dabble_seq (ports: clk, reset, start, bin, busy, done, bcd).
REQ-032 The LFSR register, request arbitration and segment decode SHALL live in param_lfsr_rng.

Verification
REQ-033 Reset release, defaults -> after 11 cycles valid pulses, bcd=16'h0000, hex digit 0 = 40.
REQ-034 Three single-cycle steps from 0, each spaced 12 cycles apart -> value 512, 768, 896; after the first step, bcd=16'h0512 and hex[6:0]=24.
REQ-035 load with seed_in=10'h3FF -> lock_err pulses once, value unchanged, busy stays 0.
REQ-036 step and load (seed_in=10'd999) in the same cycle -> value=999; after 11 cycles, bcd=16'h0999.
REQ-037 step pulsed at the cycle after acceptance, while busy=1 -> dropped, value advances exactly once.
REQ-038 BLANK_LZ=1, load 10'd7 -> hex digits 3..1 = 7F, digit 0 = 78; reset asserted mid-SHIFT -> no valid pulse.

Source files
------------

// File: rtl/lfsr_rng_pkg.sv
// rtl/lfsr_rng_pkg.sv - converter state type and seven-segment encodings
package lfsr_rng_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  // Active-low gfedcba patterns
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// rtl/bcd_dabble_seq.sv - sequential double-dabble binary to BCD converter
module bcd_dabble_seq
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned NDIG  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);

  localparam int unsigned SW = 4*NDIG + WIDTH;

  conv_state_e   state, state_next;
  logic [SW-1:0] sr, sr_next, sr_adj;
  logic [4:0]    cnt, cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (sr[WIDTH + 4*i +: 4] >= 4'd5)
        sr_adj[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  // Binary sits in the low bits; each SHIFT cycle moves one bit into the BCD field
  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          sr_next    = {{(4*NDIG){1'b0}}, bin};
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        sr_next  = sr_adj << 1;
        cnt_next = cnt + 5'd1;
        if (cnt == 5'(WIDTH - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = sr[SW-1 -: 4*NDIG];

endmodule

// File: rtl/param_lfsr_rng.sv
// rtl/param_lfsr_rng.sv - XNOR LFSR with request arbitration and BCD/seven-segment readout
module param_lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned      WIDTH    = 10,
  parameter logic [WIDTH-1:0] TAPS     = 10'h0B8,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter int unsigned      NDIG     = 4,
  parameter int unsigned      BLANK_LZ = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [WIDTH-1:0]  seed_in,
  output logic [WIDTH-1:0]  value,
  output logic [4*NDIG-1:0] bcd,
  output logic [7*NDIG-1:0] hex,
  output logic              busy,
  output logic              valid,
  output logic              lock_err
);

  logic              pending;
  logic              conv_busy, conv_done, start, reject, fb, seen;
  logic [WIDTH-1:0]  value_next;
  logic [4*NDIG-1:0] conv_bcd;
  logic [7*NDIG-1:0] hex_next;
  logic [3:0]        nib;

  assign fb   = ~^(value & TAPS);
  assign busy = conv_busy;

  // The pending cycle after reset converts SEED and swallows any request
  always_comb begin
    value_next = value;
    start      = pending;
    reject     = 1'b0;
    if (!pending && !conv_busy) begin
      if (load) begin
        if (&seed_in) begin
          reject = 1'b1;
        end else begin
          value_next = seed_in;
          start      = 1'b1;
        end
      end else if (step) begin
        value_next = {fb, value[WIDTH-1:1]};
        start      = 1'b1;
      end
    end
  end

  always_comb begin
    hex_next = '0;
    seen     = 1'b0;
    nib      = '0;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      nib = conv_bcd[4*i +: 4];
      if (BLANK_LZ != 0 && !seen && nib == 4'd0 && i != 0)
        hex_next[7*i +: 7] = SEG_BLANK;
      else
        hex_next[7*i +: 7] = seg7(nib);
      if (nib != 4'd0) seen = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value    <= SEED;
      bcd      <= '0;
      hex      <= {NDIG{SEG_BLANK}};
      valid    <= 1'b0;
      lock_err <= 1'b0;
      pending  <= 1'b1;
    end else begin
      pending  <= 1'b0;
      value    <= value_next;
      lock_err <= reject;
      valid    <= conv_done;
      if (conv_done) begin
        bcd <= conv_bcd;
        hex <= hex_next;
      end
    end
  end

  bcd_dabble_seq #(.WIDTH(WIDTH), .NDIG(NDIG)) u_dabble (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value_next),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

endmodule

// File: tb/tb_param_lfsr_rng.sv
// tb/tb_param_lfsr_rng.sv - self-checking bench for param_lfsr_rng
module tb_param_lfsr_rng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, step_a, load_a, busy_a, valid_a, lock_a;
  logic [9:0]  seed_a, value_a;
  logic [15:0] bcd_a;
  logic [27:0] hex_a;
  logic        rst_b, step_b, load_b, busy_b, valid_b, lock_b;
  logic [9:0]  seed_b, value_b;
  logic [15:0] bcd_b;
  logic [27:0] hex_b;

  param_lfsr_rng dut_a (
    .clk(clk), .reset(rst_a), .step(step_a), .load(load_a), .seed_in(seed_a),
    .value(value_a), .bcd(bcd_a), .hex(hex_a), .busy(busy_a), .valid(valid_a),
    .lock_err(lock_a)
  );

  param_lfsr_rng #(.BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(rst_b), .step(step_b), .load(load_b), .seed_in(seed_b),
    .value(value_b), .bcd(bcd_b), .hex(hex_b), .busy(busy_b), .valid(valid_b),
    .lock_err(lock_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bcd;
    logic [27:0] hex;
    int          due;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  typedef struct {
    logic       step;
    logic       load;
    logic [9:0] seed;
    logic [9:0] value;
    logic       conv;
    logic       lock;
  } vec_t;
  vec_t vecs[10];

  logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] hex_of(input int v, input bit blank);
    logic [27:0] h;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      if (blank && i > 0 && v < p * 1) h[7*i +: 7] = 7'h7F;
      else h[7*i +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return h;
  endfunction

  function automatic exp_t mk_exp(input int v, input bit blank);
    exp_t e;
    e.bcd = bcd_of(v);
    e.hex = hex_of(v, blank);
    e.due = cyc + 12;
    return e;
  endfunction

  // Scoreboard monitors: every valid must match the oldest expected result on time
  always @(negedge clk) begin
    exp_t e;
    if (valid_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL valid_a_unexpected: got valid=1 expected no conversion at cycle %0d", cyc);
      end else begin
        e = q_a.pop_front();
        chk("bcd_a", 32'(bcd_a), 32'(e.bcd));
        chk("hex_a", 32'(hex_a), 32'(e.hex));
        chk("latency_a", cyc, e.due);
      end
    end
    if (q_a.size() > 0 && cyc > q_a[0].due) begin
      e = q_a.pop_front();
      checks++; errors++;
      $display("FAIL valid_a_missing: got no valid by cycle %0d expected at %0d", cyc, e.due);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL valid_b_unexpected: got valid=1 expected no conversion at cycle %0d", cyc);
      end else begin
        e = q_b.pop_front();
        chk("bcd_b", 32'(bcd_b), 32'(e.bcd));
        chk("hex_b", 32'(hex_b), 32'(e.hex));
        chk("latency_b", cyc, e.due);
      end
    end
    if (q_b.size() > 0 && cyc > q_b[0].due) begin
      e = q_b.pop_front();
      checks++; errors++;
      $display("FAIL valid_b_missing: got no valid by cycle %0d expected at %0d", cyc, e.due);
    end
  end

  task automatic drain_a();
    for (int i = 0; i < 40 && q_a.size() > 0; i++) @(negedge clk);
    chk("drain_a", q_a.size(), 0);
    @(negedge clk);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 40 && q_b.size() > 0; i++) @(negedge clk);
    chk("drain_b", q_b.size(), 0);
    @(negedge clk);
  endtask

  task automatic apply_a(input vec_t v);
    step_a = v.step; load_a = v.load; seed_a = v.seed;
    if (v.conv) q_a.push_back(mk_exp(int'(v.value), 1'b0));
    @(negedge clk);
    chk("value_a", 32'(value_a), 32'(v.value));
    chk("lock_err_a", 32'(lock_a), 32'(v.lock));
    chk("busy_a", 32'(busy_a), 32'(v.conv));
    step_a = 1'b0; load_a = 1'b0;
    @(negedge clk);
    chk("lock_err_a_pulse", 32'(lock_a), 0);
    drain_a();
  endtask

  task automatic load_b_val(input int v);
    load_b = 1'b1; seed_b = 10'(v);
    q_b.push_back(mk_exp(v, 1'b1));
    @(negedge clk);
    load_b = 1'b0;
    chk("value_b", 32'(value_b), v);
    drain_b();
  endtask

  initial begin
    rst_a = 1'b0; step_a = 1'b0; load_a = 1'b0; seed_a = '0;
    rst_b = 1'b0; step_b = 1'b0; load_b = 1'b0; seed_b = '0;

    vecs[0] = '{1'b1, 1'b0, 10'd0,    10'd512,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 10'd0,    10'd768,  1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 10'd0,    10'd896,  1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 10'h3FF,  10'd896,  1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 10'd999,  10'd999,  1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 10'd5,    10'd5,    1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 10'd0,    10'd514,  1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 10'd0,    10'd0,    1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 10'd1000, 10'd1000, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 10'd0,    10'd500,  1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_value", 32'(value_a), 0);
    chk("rst_bcd", 32'(bcd_a), 0);
    chk("rst_hex", 32'(hex_a), 32'h0FFF_FFFF);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_lock_err", 32'(lock_a), 0);

    // Release: SEED conversion starts on the first edge, request in that cycle ignored
    rst_a = 1'b1; step_a = 1'b1;
    q_a.push_back(mk_exp(0, 1'b0));
    @(negedge clk);
    step_a = 1'b0;
    chk("pending_ignores_step", 32'(value_a), 0);
    chk("pending_busy", 32'(busy_a), 1);
    drain_a();

    for (int i = 0; i < 10; i++) apply_a(vecs[i]);

    // Second step while busy must be dropped
    step_a = 1'b1;
    q_a.push_back(mk_exp(250, 1'b0));
    @(negedge clk);
    chk("busy_step_first", 32'(value_a), 250);
    @(negedge clk);
    step_a = 1'b0;
    chk("busy_step_dropped", 32'(value_a), 250);
    drain_a();
    chk("busy_step_final", 32'(value_a), 250);

    // Blanking instance
    repeat (2) @(negedge clk);
    chk("rst_hex_b", 32'(hex_b), 32'h0FFF_FFFF);
    rst_b = 1'b1;
    q_b.push_back(mk_exp(0, 1'b1));
    @(negedge clk);
    drain_b();
    load_b_val(7);
    load_b_val(305);
    load_b_val(40);

    // Reset mid-SHIFT aborts the conversion with no valid
    load_b = 1'b1; seed_b = 10'd9;
    @(negedge clk);
    load_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 32'(busy_b), 1);
    rst_b = 1'b0;
    #1;
    chk("abort_value", 32'(value_b), 0);
    chk("abort_busy", 32'(busy_b), 0);
    chk("abort_hex", 32'(hex_b), 32'h0FFF_FFFF);
    chk("abort_bcd", 32'(bcd_b), 0);
    repeat (15) @(negedge clk);
    rst_b = 1'b1;
    q_b.push_back(mk_exp(0, 1'b1));
    @(negedge clk);
    drain_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
